// File: rtl/period_timer_pkg.sv
// Shared definitions for the timer blocks: operating mode encodings.
package period_timer_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides qualified strobes down to count steps: one step every div+1 strobes.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             strobe,
  input  logic [PRE_W-1:0] div,
  output logic             step
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  // div only changes together with clr, so cnt_q never passes div
  assign step = strobe && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/period_timer.sv
// Prescaled period timer with periodic and one-shot modes, registered tick,
// sticky done flag and busy indication.
module period_timer
  import period_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             incr,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  input  logic             oneshot,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] number
);

  logic [WIDTH-1:0] per_q, per_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic qual_strobe;
  logic step;
  logic terminal;

  // A load in the same cycle swallows the strobe
  assign qual_strobe = busy_q & en & incr & ~load;
  assign terminal    = step && (number_q == per_q);

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .strobe (qual_strobe),
    .div    (pre_q),
    .step   (step)
  );

  always_comb begin
    per_d    = per_q;
    pre_d    = pre_q;
    mode_d   = mode_q;
    number_d = number_q;
    done_d   = done_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;
    if (load) begin
      per_d    = period;
      pre_d    = prescale;
      mode_d   = mode_e'(oneshot);
      number_d = '0;
      done_d   = 1'b0;
      busy_d   = 1'b1;
    end else if (terminal) begin
      number_d = '0;
      tick_d   = 1'b1;
      if (mode_q == MODE_ONESHOT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (step) begin
      number_d = number_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q    <= '0;
      pre_q    <= '0;
      mode_q   <= MODE_PERIODIC;
      number_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      per_q    <= per_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
      number_q <= number_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign tick   = tick_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign number = number_q;

endmodule

// File: tb/tb_period_timer.sv
// Bench for period_timer: directed scenarios then random traffic, all checked
// against a strobe-counting reference model.
module tb_period_timer;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             incr;
  logic             load;
  logic [WIDTH-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             oneshot;
  logic             tick;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] number;

  int checks   = 0;
  int failures = 0;
  int tick_seen = 0;

  // Reference model: strobes counted since load/wrap; number derived arithmetically
  int m_per, m_pre, m_cnt;
  bit m_mode, m_busy, m_done, m_tick;

  period_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .incr     (incr),
    .load     (load),
    .period   (period),
    .prescale (prescale),
    .oneshot  (oneshot),
    .tick     (tick),
    .done     (done),
    .busy     (busy),
    .number   (number)
  );

  always #5 clk = ~clk;

  function automatic int m_number();
    return (m_cnt / (m_pre + 1)) % (m_per + 1);
  endfunction

  task automatic model_reset();
    m_per = 0; m_pre = 0; m_cnt = 0;
    m_mode = 0; m_busy = 0; m_done = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    if (load) begin
      m_per  = int'(period);
      m_pre  = int'(prescale);
      m_mode = oneshot;
      m_cnt  = 0;
      m_done = 0;
      m_busy = 1;
    end else if (m_busy && en && incr) begin
      m_cnt++;
      if (m_cnt % ((m_pre + 1) * (m_per + 1)) == 0) begin
        m_tick = 1;
        m_cnt  = 0;
        if (m_mode) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".tick"},   32'(tick),   32'(m_tick));
    chk({tag, ".done"},   32'(done),   32'(m_done));
    chk({tag, ".busy"},   32'(busy),   32'(m_busy));
    chk({tag, ".number"}, 32'(number), 32'(m_number()));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (tick === 1'b1) tick_seen++;
    chk_all(tag);
  endtask

  task automatic do_load(input int p, input int pr, input bit os, input bit inc);
    period = WIDTH'(p); prescale = PRE_W'(pr); oneshot = os;
    load = 1'b1; incr = inc;
    cyc("load");
    load = 1'b0; incr = 1'b0;
    tick_seen = 0;
  endtask

  task automatic strobes(input string tag, input int n);
    incr = 1'b1;
    repeat (n) cyc(tag);
    incr = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; incr = 1'b0; load = 1'b0;
    period = '0; prescale = '0; oneshot = 1'b0;
    model_reset();
    #3;
    chk_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;

    // Idle after reset: strobes ignored until a load
    strobes("idle", 4);

    // Periodic, period=3: tick every 4 strobes
    do_load(3, 0, 0, 0);
    strobes("periodic", 12);
    chk("periodic.ticks", 32'(tick_seen), 32'd3);

    // Prescale 2, period 1: tick every 6 strobes
    do_load(1, 2, 0, 0);
    strobes("prescale", 12);
    chk("prescale.ticks", 32'(tick_seen), 32'd2);

    // One-shot, period 2, 5 strobes: single tick then frozen
    do_load(2, 0, 1, 0);
    strobes("oneshot", 5);
    chk("oneshot.ticks", 32'(tick_seen), 32'd1);
    chk("oneshot.done", 32'(done), 32'd1);

    // Load wins over same-cycle incr, then reload mid-count
    do_load(3, 0, 0, 1);
    chk("ldprio.number", 32'(number), 32'd0);
    strobes("ldprio", 2);
    chk("ldprio.mid", 32'(number), 32'd2);
    do_load(5, 0, 0, 1);
    strobes("reload", 5);
    chk("reload.noTick", 32'(tick_seen), 32'd0);
    strobes("reload", 1);
    cyc("reload.idle");
    chk("reload.tick6", 32'(tick_seen), 32'd1);

    // Enable low freezes counting; reset mid-count abandons it
    do_load(7, 0, 0, 0);
    strobes("en", 4);
    en = 1'b0;
    strobes("enlow", 3);
    chk("enlow.number", 32'(number), 32'd4);
    en = 1'b1;
    pulse_reset("midrst");
    tick_seen = 0;
    strobes("postrst", 10);
    chk("postrst.ticks", 32'(tick_seen), 32'd0);

    // Boundaries: period 0 and full-range period
    do_load(0, 0, 0, 0);
    strobes("per0", 8);
    chk("per0.ticks", 32'(tick_seen), 32'd8);
    do_load(255, 0, 0, 0);
    strobes("per255", 255);
    chk("per255.pre", 32'(number), 32'd255);
    chk("per255.noTick", 32'(tick_seen), 32'd0);
    strobes("per255", 1);
    chk("per255.ticks", 32'(tick_seen), 32'd1);
    chk("per255.wrap", 32'(number), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        period   = ($urandom_range(0, 5) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
        prescale = PRE_W'($urandom_range(0, 3));
        oneshot  = $urandom_range(0, 1) == 1;
      end
      en   = ($urandom_range(0, 9) != 0);
      incr = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset("rnd.rst");
      end
      cyc("rnd");
    end
    load = 1'b0; incr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_timer.md
PERIOD_TIMER -- requirements
Module: period_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of period register and count.
REQ-002 SHALL have parameter PRE_W, default 4: bit width of prescale register.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1: global enable; low freezes all counting state.
REQ-006 SHALL have port incr, input, 1: count-event strobe, sampled each clk.
REQ-007 SHALL have port load, input, 1: latch period, prescale and mode, then restart the timer.
REQ-008 SHALL have port period, input, WIDTH: terminal count; a tick occurs every period+1 steps.
REQ-009 SHALL have port prescale, input, PRE_W: a step occurs every prescale+1 qualified incr strobes.
REQ-010 SHALL have port oneshot, input, 1: 0 = periodic, 1 = one-shot.
REQ-011 SHALL have port tick, output, 1: registered one-cycle pulse on terminal count.
REQ-012 SHALL have port done, output, 1: sticky one-shot completion flag.
REQ-013 SHALL have port busy, output, 1: timer armed and counting.
REQ-014 SHALL have port number, output, WIDTH: current count.

Function
REQ-015 SHALL treat a qualified strobe as busy & en & incr & !load.
REQ-016 SHALL hold prescaler pre_cnt (PRE_W bits); on a qualified strobe: if pre_cnt==pre_reg, produce a step and set pre_cnt to 0, else increment pre_cnt.
REQ-017 SHALL, on a step with number!=per_reg, increment number by 1.
REQ-018 SHALL, on a step with number==per_reg, set number to 0 and assert tick in the next cycle for exactly one cycle.
REQ-019 SHALL, with per_reg==0, tick on every step with number held at 0.
REQ-020 SHALL, in one-shot mode, also clear busy and set done on the terminal step; later strobes change nothing.
REQ-021 SHALL, in periodic mode, keep busy high and continue counting after the wrap.
REQ-022 SHALL, on load (regardless of en or busy), latch per_reg=period, pre_reg=prescale, mode=oneshot; clear number, pre_cnt and done; set busy=1.
REQ-023 SHALL give load priority over a same-cycle incr; that incr is discarded.
REQ-024 SHALL, while en is low, hold number, pre_cnt, busy and done, and keep tick low.
REQ-025 SHALL keep tick low in all cycles except those defined by REQ-018.
REQ-026 SHALL have a latency of exactly one clk from the terminal strobe to tick (and to done/busy update).
REQ-027 SHALL ensure number never exceeds per_reg; arithmetic is unsigned modulo per_reg+1, with no overflow at per_reg = 2^WIDTH-1.

Reset
REQ-028 SHALL, on rst high and asynchronously, set number=0, pre_cnt=0, per_reg=0, pre_reg=0, mode=0, tick=0, done=0, busy=0.
REQ-029 SHALL be idle after reset: incr is ignored until the first load.
REQ-030 SHALL, on rst mid-count, abandon the current count completely; no tick is emitted after reset.

Structure
REQ-031 SHALL place the mode encodings MODE_PERIODIC=0 and MODE_ONESHOT=1 in a shared package/header used by timer blocks.
REQ-032 SHALL implement the prescaler as one sub-module, tick_prescaler (inputs clk, rst, clr, strobe, div; output step).
REQ-033 SHALL keep the remaining counter, mode logic and flag logic in period_timer.

Verification
REQ-034 Periodic: load period=3, prescale=0, en=1, incr held high -> tick one cycle after number 3, then every 4 cycles; number sequence 0,1,2,3,0.
REQ-035 Prescale: period=1, prescale=2, incr held high -> step every 3 strobes, tick every 6 strobes.
REQ-036 One-shot: period=2, oneshot=1, 5 strobes -> single tick after the 3rd strobe; done=1 and busy=0 from the next cycle; number=0 thereafter.
REQ-037 Load priority and reload: load and incr in the same cycle, then load period=5 while number=2 -> number=0, that incr ignored, and the next tick only after 6 further strobes.
REQ-038 Enable/reset: en=0 during 3 strobes -> number unchanged and no tick; rst pulse at number=4 with period=7 -> all outputs 0, no tick until a new load.
REQ-039 Boundaries: period=0 -> tick on every strobe; WIDTH=8, period=255 -> tick after strobe 256 and number wraps to 0.
